// File: rtl/audio_adc_i2s_rx.sv
// I2S slave receiver for the codec ADC path: oversamples BCLK/ADCLRCK/ADCDAT on clk_clk,
// assembles left/right words and buffers stereo pairs in a small FWFT FIFO.
module audio_adc_i2s_rx #(
  parameter int DATA_WIDTH  = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic                          audio_BCLK,
  input  logic                          audio_ADCLRCK,
  input  logic                          audio_ADCDAT,
  input  logic                          enable,
  output logic [DATA_WIDTH-1:0]         sample_left,
  output logic [DATA_WIDTH-1:0]         sample_right,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clear_overflow,
  output logic [1:0]                    fsm_state
);

  localparam int CW   = $clog2(DATA_WIDTH + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam logic [CW-1:0] DW_C = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, dat_sync;
  logic                   sync_bclk, sync_lrck, sync_dat;
  logic                   bclk_d, lrck_prev;
  logic                   bclk_rise, lrck_edge;

  logic [DATA_WIDTH-1:0]  shreg, word_val, held_left;
  logic [CW-1:0]          bit_cnt;
  logic                   channel_lrck, held_valid;
  logic                   word_done, enter_skip, shift_en;

  logic [DATA_WIDTH-1:0]  left_mem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  right_mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [LW-1:0]          count;
  logic                   full, push, push_ok, pop;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], audio_BCLK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], audio_ADCLRCK};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], audio_ADCDAT};
    end
  end

  assign sync_bclk = bclk_sync[SYNC_STAGES-1];
  assign sync_lrck = lrck_sync[SYNC_STAGES-1];
  assign sync_dat  = dat_sync[SYNC_STAGES-1];
  assign bclk_rise = sync_bclk & ~bclk_d;
  assign lrck_edge = bclk_rise & (sync_lrck != lrck_prev);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_next;
  end

  // The rise that reveals an LRCK edge carries the I2S delay bit, so entering SKIP
  // on that rise discards it; the rise that leaves SKIP already carries the MSB.
  always_comb begin
    state_next = state;
    word_done  = 1'b0;
    word_val   = '0;
    enter_skip = 1'b0;
    shift_en   = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else if (bclk_rise) begin
      case (state)
        IDLE: begin
          if (lrck_edge && !sync_lrck) begin
            state_next = SKIP;
            enter_skip = 1'b1;
          end
        end
        SKIP: begin
          state_next = SHIFT;
          shift_en   = 1'b1;
        end
        SHIFT: begin
          if (lrck_edge) begin
            word_done  = 1'b1;
            word_val   = shreg << (DW_C - bit_cnt);
            state_next = SKIP;
            enter_skip = 1'b1;
          end else begin
            shift_en = 1'b1;
            if (bit_cnt == DW_C - 1'b1) begin
              word_done  = 1'b1;
              word_val   = {shreg[DATA_WIDTH-2:0], sync_dat};
              state_next = WAIT;
            end
          end
        end
        WAIT: begin
          if (lrck_edge) begin
            state_next = SKIP;
            enter_skip = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      bclk_d       <= 1'b0;
      lrck_prev    <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
      channel_lrck <= 1'b0;
      held_left    <= '0;
      held_valid   <= 1'b0;
    end else begin
      bclk_d <= sync_bclk;
      if (bclk_rise) lrck_prev <= sync_lrck;
      if (enter_skip) begin
        shreg        <= '0;
        bit_cnt      <= '0;
        channel_lrck <= sync_lrck;
      end else if (shift_en) begin
        shreg   <= {shreg[DATA_WIDTH-2:0], sync_dat};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (!enable) begin
        held_valid <= 1'b0;
      end else if (word_done) begin
        if (!channel_lrck) begin
          held_left  <= word_val;
          held_valid <= 1'b1;
        end else begin
          held_valid <= 1'b0;
        end
      end
    end
  end

  // Output handshake: a pair transfers on every clk_clk edge where sample_valid and
  // sample_ready are both high; the head stays stable while valid is high and ready low.
  assign push    = word_done & channel_lrck & held_valid;
  assign full    = (count == LW'(FIFO_DEPTH));
  assign pop     = sample_valid & sample_ready;
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        left_mem[i]  <= '0;
        right_mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        left_mem[wr_ptr]  <= held_left;
        right_mem[wr_ptr] <= word_val;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      else if (clear_overflow)  overflow <= 1'b0;
    end
  end

  assign sample_left  = left_mem[rd_ptr];
  assign sample_right = right_mem[rd_ptr];
  assign sample_valid = (count != '0);
  assign fifo_level   = count;
  assign fsm_state    = state;

endmodule
